fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Parametrised successor to the single-entry IF/ID pipeline register: a DEPTH-entry instruction queue between instruction memory and decode. It holds instruction/PC pairs so fetch can run ahead while decode is stalled. It supports a valid/ready push interface, stall (hazard) hold, and flush to empty. Bubbles are presented to decode as all-zero instruction and NPC (MIPS NOP).

Parameters:
INSTR_W, 32, instruction width in bits
PC_W, 32, PC/NPC width in bits
DEPTH, 4, queue entries; power of two, >= 2
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived; not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  fetch offers an entry
in_ready  output  1  queue accepts the entry this cycle
in_pc  input  PC_W  NPC of the offered instruction
in_instr  input  INSTR_W  offered instruction word
flush_in  input  1  branch/jump flush; empties the queue
hazard_in  input  1  decode stall; head is not consumed
out_valid  output  1  head entry is valid
out_instr  output  INSTR_W  head instruction; 0 when out_valid=0
out_npc  output  PC_W  head NPC; 0 when out_valid=0
count  output  CNT_W  current occupancy, 0..DEPTH

Behaviour:
- Reset (rst_n low, async): read ptr = write ptr = 0, count = 0, storage contents don't-care. Outputs out_valid=0, out_instr=0, out_npc=0, count=0, in_ready=1. Reset asserted mid-operation discards all entries immediately.
- Storage: circular buffer, log2(DEPTH)-bit read/write pointers that wrap naturally at DEPTH-1 -> 0.
- in_ready = (count != DEPTH). This is purely combinational from count and does not look at pop or flush. A push when full is never accepted, even if a pop happens in the same cycle.
- push = in_valid & in_ready & ~flush_in. On push: write [in_instr, in_pc] at the write pointer, then increment the write pointer.
- pop = out_valid & ~hazard_in & ~flush_in. On pop: increment the read pointer. Decode consumes the head on any edge where out_valid=1 and hazard_in=0.
- count next value: +1 on push only, -1 on pop only, unchanged on both or neither.
- Output timing: out_valid = (count != 0). out_instr/out_npc are the head entry, gated to 0 when empty. An entry pushed at edge N is visible at the output after edge N (one-cycle latency) if the queue was empty.
- hazard_in=1: head held stable, no pop; pushes still accepted until full. This differs from the old stage, which dropped to a bubble.
- flush_in=1: at the next edge, pointers and count go to 0. It overrides any same-cycle push and pop; the offered entry is dropped and fetch must re-present from the new PC. Outputs read 0 the cycle after.
- flush_in and hazard_in both high: flush wins.
- Empty with hazard_in=0: outputs are 0 (NOP bubble), out_valid=0.
- No combinational path from in_* to out_*.

Optional Feature:
Macro: FETCH_QUEUE_STATS_EN.

When defined, two extra outputs are added:
- stall_cycles (32-bit): increments on every edge with out_valid=1 and hazard_in=1 and flush_in=0; saturates at all-ones.
- full_cycles (32-bit): increments on every edge with count==DEPTH; saturates at all-ones.

Both counters reset to 0 on rst_n only; flush does not clear them.

When not defined, these ports and registers do not exist, and the functional behaviour is identical.

Decomposition:
- Shared package fetch_pkg holds:
  - NOP_INSTR constant (32'h0000_0000)
  - default widths (INSTR_W, PC_W)
  - fetch_entry_t struct {instr, npc}, used by fetch and decode
- One natural sub-module: fetch_queue_mem, a DEPTH x (INSTR_W+PC_W) register array with a synchronous write port and an asynchronous read port. Pointer, count and flush logic stay in fetch_queue.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then release -> out_valid=0, out_instr=0, out_npc=0, count=0, in_ready=1.
- Push 4 words, no hazard (0x2001_0001 with pc 0x4, +4 each) -> each appears at the output the cycle after its push, in order; count never exceeds 1.
- hazard_in=1 while pushing 5 offers -> count reaches 4, in_ready=0, 5th offer held by source. Release hazard -> heads 0x4, 0x8, 0xC, 0x10, then the 5th entry, in order.
- Full queue with flush_in=1 and in_valid=1 in the same cycle -> next cycle count=0, out_valid=0, outputs 0; the offered entry is never seen.
- Pointer wrap: push/pop 3*DEPTH+1 entries with random hazard -> output sequence equals input sequence, no loss or duplication.
- Async reset mid-stream: assert rst_n=0 between edges while count=3 -> outputs zero immediately, without waiting for a clock edge.
- STATS build: 6 hazard cycles with a valid head -> stall_cycles=6. Then fill to 4 and hold 3 cycles -> full_cycles=3. Flush -> counters unchanged.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch/decode types: NOP encoding, default widths, instruction entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

  localparam int DEF_INSTR_W = 32;
  localparam int DEF_PC_W    = 32;

  // All-zero word is the MIPS NOP presented to decode as a bubble.
  localparam logic [DEF_INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [DEF_INSTR_W-1:0] instr;
    logic [DEF_PC_W-1:0]    npc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: DEPTH x W registers.
// Latency: write lands on the clock edge; read is combinational from the address.
// Backpressure: none; the caller only writes when the queue has room.
module fetch_queue_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [W-1:0]  i_wr_dat,
  input  logic [AW-1:0] i_rd_addr,
  output logic [W-1:0]  o_rd_dat
);

  logic [W-1:0] r_mem [DEPTH];

  // Write port; contents need no reset because the count masks stale slots
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_dat;
    end
  end

  assign o_rd_dat = r_mem[i_rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// DEPTH-entry instruction queue between instruction memory and decode.
// Latency: an entry pushed into an empty queue is visible at the head one cycle later.
// Backpressure: in_ready drops when full; hazard_in holds the head, flush_in empties.
// Optional stall/full statistics counters are built when FETCH_QUEUE_STATS_EN is defined.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int PC_W    = DEF_PC_W,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush_in,
  input  logic               hazard_in,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_npc,
  output logic [CNT_W-1:0]   count
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        full_cycles
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = INSTR_W + PC_W;

  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_push;
  logic             w_pop;
  logic [ENT_W-1:0] w_rd_dat;

  // Ready looks only at occupancy, so a full queue refuses even when popping.
  assign in_ready  = (r_count != CNT_W'(DEPTH));
  assign out_valid = (r_count != '0);
  assign count     = r_count;

  assign w_push = in_valid & in_ready & ~flush_in;
  assign w_pop  = out_valid & ~hazard_in & ~flush_in;

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .W     (ENT_W),
    .AW    (PTR_W)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_dat  ({in_instr, in_pc}),
    .i_rd_addr (r_rd_ptr),
    .o_rd_dat  (w_rd_dat)
  );

  // Empty queue presents a NOP bubble with zero NPC.
  assign out_instr = out_valid ? w_rd_dat[ENT_W-1 -: INSTR_W] : INSTR_W'(NOP_INSTR);
  assign out_npc   = out_valid ? w_rd_dat[PC_W-1:0] : '0;

  // Pointer and occupancy update; flush overrides any same-cycle push or pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush_in) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_full_cycles;

  // Saturating stall/full counters; only reset clears them, flush does not
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
      r_full_cycles  <= '0;
    end else begin
      if (out_valid && hazard_in && !flush_in && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (!in_ready && (r_full_cycles != '1)) begin
        r_full_cycles <= r_full_cycles + 32'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign full_cycles  = r_full_cycles;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized self-checking bench for fetch_queue against a queue-based reference model.
// Latency: model and DUT compared every cycle on the falling edge.
// Backpressure: a source queue holds each offer until the model says it was accepted.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH   = 4;
  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic               clk       = 1'b0;
  logic               rst_n     = 1'b0;
  logic               in_valid  = 1'b0;
  logic [PC_W-1:0]    in_pc     = '0;
  logic [INSTR_W-1:0] in_instr  = '0;
  logic               flush_in  = 1'b0;
  logic               hazard_in = 1'b0;
  logic               in_ready;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_npc;
  logic [CNT_W-1:0]   count;
`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0]        stall_cycles;
  logic [31:0]        full_cycles;
`endif

  always #5 clk = ~clk;

  fetch_queue #(
    .INSTR_W (INSTR_W),
    .PC_W    (PC_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_instr     (in_instr),
    .flush_in     (flush_in),
    .hazard_in    (hazard_in),
    .out_valid    (out_valid),
    .out_instr    (out_instr),
    .out_npc      (out_npc),
    .count        (count)
`ifdef FETCH_QUEUE_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .full_cycles  (full_cycles)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  fetch_entry_t mq[$];      // reference queue contents, head at index 0
  fetch_entry_t src[$];     // entries fetch still has to present
  logic [31:0]  got_seq[$]; // instructions the DUT handed to decode
  longint       m_stall = 0;
  longint       m_full  = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    fetch_entry_t h;
    h = (mq.size() > 0) ? mq[0] : '0;
    check_val("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    check_val("out_instr", 64'(out_instr), 64'(h.instr));
    check_val("out_npc",   64'(out_npc),   64'(h.npc));
    check_val("count",     64'(count),     64'(mq.size()));
    check_val("in_ready",  64'(in_ready),  64'(mq.size() != DEPTH));
`ifdef FETCH_QUEUE_STATS_EN
    check_val("stall_cycles", 64'(stall_cycles), 64'(m_stall));
    check_val("full_cycles",  64'(full_cycles),  64'(m_full));
`endif
  endtask

  // One clock: present the next source entry if asked, advance model, compare.
  task automatic step(input bit offer);
    bit push, pop;
    if (offer && src.size() > 0) begin
      in_valid = 1'b1;
      in_instr = src[0].instr;
      in_pc    = src[0].npc;
    end else begin
      in_valid = 1'b0;
      in_instr = '0;
      in_pc    = '0;
    end
    push = in_valid && (mq.size() < DEPTH) && !flush_in;
    pop  = (mq.size() > 0) && !hazard_in && !flush_in;
    if (pop) got_seq.push_back(out_instr);
    if ((mq.size() > 0) && hazard_in && !flush_in) m_stall++;
    if (mq.size() == DEPTH) m_full++;
    @(posedge clk);
    if (flush_in) begin
      mq.delete();
    end else begin
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(src[0]);
    end
    if (push) void'(src.pop_front());
    @(negedge clk);
    check_outputs();
  endtask

  function automatic fetch_entry_t mk(input logic [31:0] instr, input logic [31:0] pc);
    fetch_entry_t e;
    e.instr = instr;
    e.npc   = pc;
    return e;
  endfunction

  initial begin
    // Reset held for two cycles, then idle
    @(negedge clk);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_count",     64'(count),     64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs();
    step(1'b0);

    // Streaming with no hazard: each entry appears one cycle after its push
    for (int i = 0; i < 4; i++) src.push_back(mk(32'h2001_0001 + 32'(i), 32'h4 + 32'(4 * i)));
    for (int i = 0; i < 4; i++) begin
      step(1'b1);
      check_val("stream_head", 64'(out_instr), 64'(32'h2001_0001 + 32'(i)));
      check_val("stream_npc",  64'(out_npc),   64'(32'h4 + 32'(4 * i)));
      check_val("stream_cnt",  64'(count),     64'd1);
    end
    step(1'b0);

    // Hazard while fetch offers five: fills to DEPTH, fifth is held back
    got_seq.delete();
    for (int i = 0; i < 5; i++) src.push_back(mk(32'h3000_0000 + 32'(i), 32'h4 + 32'(4 * i)));
    hazard_in = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1);
    check_val("hz_full_cnt",   64'(count),    64'd4);
    check_val("hz_full_rdy",   64'(in_ready), 64'd0);
    check_val("hz_head_npc",   64'(out_npc),  64'h4);
    hazard_in = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b1);
    check_val("hz_drain_len", 64'(got_seq.size()), 64'd5);
    for (int i = 0; i < 5 && i < got_seq.size(); i++)
      check_val("hz_drain_ord", 64'(got_seq[i]), 64'(32'h3000_0000 + 32'(i)));

    // Flush of a full queue with a same-cycle offer that must be dropped
    hazard_in = 1'b1;
    for (int i = 0; i < 4; i++) src.push_back(mk(32'h4000_0000 + 32'(i), 32'h100 + 32'(4 * i)));
    for (int i = 0; i < 4; i++) step(1'b1);
    src.push_back(mk(32'hDEAD_BEEF, 32'hBAD0));
    flush_in = 1'b1;
    step(1'b1);
    flush_in  = 1'b0;
    hazard_in = 1'b0;
    src.delete();
    check_val("flush_cnt",   64'(count),     64'd0);
    check_val("flush_valid", 64'(out_valid), 64'd0);
    check_val("flush_instr", 64'(out_instr), 64'd0);
    step(1'b0);

    // Pointer wrap with random hazard and random offers
    got_seq.delete();
    for (int i = 0; i < 3 * DEPTH + 1; i++) src.push_back(mk($urandom, $urandom));
    begin
      fetch_entry_t sent[$];
      sent = src;
      for (int c = 0; c < 400 && got_seq.size() < sent.size(); c++) begin
        hazard_in = ($urandom_range(0, 2) == 0);
        step($urandom_range(0, 3) != 0);
      end
      hazard_in = 1'b0;
      check_val("wrap_len", 64'(got_seq.size()), 64'(sent.size()));
      for (int i = 0; i < sent.size() && i < got_seq.size(); i++)
        check_val("wrap_ord", 64'(got_seq[i]), 64'(sent[i].instr));
    end

`ifdef FETCH_QUEUE_STATS_EN
    // Stall and full counters, then confirm flush does not clear them
    begin
      logic [31:0] b_stall, b_full;
      src.push_back(mk(32'h5000_0000, 32'h200));
      step(1'b1);
      b_stall   = stall_cycles;
      hazard_in = 1'b1;
      for (int i = 0; i < 6; i++) step(1'b0);
      check_val("stats_stall6", 64'(stall_cycles - b_stall), 64'd6);
      for (int i = 0; i < 3; i++) src.push_back(mk(32'h5000_0001 + 32'(i), 32'h204 + 32'(4 * i)));
      for (int i = 0; i < 3; i++) step(1'b1);
      b_full = full_cycles;
      for (int i = 0; i < 3; i++) step(1'b0);
      check_val("stats_full3", 64'(full_cycles - b_full), 64'd3);
      b_stall  = stall_cycles;
      b_full   = full_cycles;
      flush_in = 1'b1;
      step(1'b0);
      flush_in  = 1'b0;
      hazard_in = 1'b0;
      check_val("stats_flush_stall", 64'(stall_cycles), 64'(b_stall));
      check_val("stats_flush_full",  64'(full_cycles),  64'(b_full + 32'd1));
      step(1'b0);
    end
`endif

    // Asynchronous reset between edges with three entries queued
    hazard_in = 1'b1;
    for (int i = 0; i < 3; i++) src.push_back(mk(32'h6000_0000 + 32'(i), 32'h300 + 32'(4 * i)));
    for (int i = 0; i < 3; i++) step(1'b1);
    check_val("arst_pre_cnt", 64'(count), 64'd3);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    mq.delete();
    src.delete();
    m_stall = 0;
    m_full  = 0;
    check_val("arst_valid", 64'(out_valid), 64'd0);
    check_val("arst_instr", 64'(out_instr), 64'd0);
    check_val("arst_npc",   64'(out_npc),   64'd0);
    check_val("arst_cnt",   64'(count),     64'd0);
    check_val("arst_rdy",   64'(in_ready),  64'd1);
    #2;
    rst_n     = 1'b1;
    hazard_in = 1'b0;
    step(1'b0);
    step(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
